// File: rtl/bus_cycle_ctrl_if.sv
// bus_cycle_ctrl_if: memory-side request/acknowledge bus between the bus
// cycle controller (master) and the memory/peripheral fabric (slave).
`timescale 1ns/1ps

interface bus_cycle_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: turns phi_2 edges into one memory transaction per CPU
// cycle. A late acknowledge stalls the CPU via cpu_rdy; the repeated CPU
// cycle is then served from held data without a second request.
// Optional feature: define BUS_TIMEOUT_EN to build a request timeout that
// forces completion (read data all ones, one-cycle bus_err pulse).
`timescale 1ns/1ps

module bus_cycle_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               phi_2,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic               cpu_rw,
  input  logic [DATA_W-1:0]  cpu_dout,
  output logic [DATA_W-1:0]  cpu_din,
  output logic               cpu_rdy,
  output logic               bus_err,
  bus_cycle_ctrl_if.master   mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    STALL = 2'd3
  } state_t;

  // The timeout counter is 8 bits wide, so only 1..255 is meaningful.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("bus_cycle_ctrl: TIMEOUT must be in 1..255");
  end

  state_t            state_q, state_d;
  logic              phi_d_q;
  logic              replay_q, replay_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_din_q, cpu_din_d;
  logic              cpu_rdy_q, cpu_rdy_d;
  logic              bus_err_q, bus_err_d;

  logic              rise;
  logic              fall;
  logic              timeout;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  // phi_2 is already a clk-domain signal, so a single delay flop is enough.
  assign rise = phi_2 & ~phi_d_q;
  assign fall = ~phi_2 & phi_d_q;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  // Firing one count early makes mem_req stay high for exactly TIMEOUT clks.
  assign timeout = mem_req_q & ~mem.mem_ack & (tmo_cnt_q == TIMEOUT_LAST);
`else
  assign timeout = 1'b0;
`endif

  // A timeout is treated exactly like an acknowledge carrying all-ones data.
  assign ack   = (mem_req_q & mem.mem_ack) | timeout;
  assign rdata = timeout ? {DATA_W{1'b1}} : mem.mem_rdata;

  // Next-state and next-output logic for the transaction state machine.
  always_comb begin
    state_d     = state_q;
    replay_d    = replay_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_din_d   = cpu_din_q;
    cpu_rdy_d   = cpu_rdy_q;
    bus_err_d   = timeout;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          if (replay_q) begin
            replay_d = 1'b0;
            state_d  = DONE;
          end else begin
            mem_addr_d  = cpu_addr;
            mem_we_d    = ~cpu_rw;
            mem_wdata_d = cpu_dout;
            mem_req_d   = 1'b1;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (ack) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            cpu_din_d = rdata;
          end
          // An ack on the fall edge consumes that fall, so skip DONE.
          state_d = fall ? IDLE : DONE;
        end else if (fall) begin
          cpu_rdy_d = 1'b0;
          state_d   = STALL;
        end
      end
      DONE: begin
        if (fall) begin
          state_d = IDLE;
        end
      end
      STALL: begin
        if (ack) begin
          mem_req_d = 1'b0;
          cpu_rdy_d = 1'b1;
          if (!mem_we_q) begin
            cpu_din_d = rdata;
          end
          // If the repeated cycle starts on this very edge, serve it now.
          if (rise) begin
            state_d = DONE;
          end else begin
            replay_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  // Count clks while a request stays open; restart when it closes.
  always_comb begin
    tmo_cnt_d = 8'd0;
    if (mem_req_q && mem_req_d) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
  end
`endif

  // All state and registered outputs; reset aborts any open transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phi_d_q     <= 1'b0;
      replay_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_din_q   <= '0;
      cpu_rdy_q   <= 1'b1;
      bus_err_q   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_q   <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      phi_d_q     <= phi_2;
      replay_q    <= replay_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_din_q   <= cpu_din_d;
      cpu_rdy_q   <= cpu_rdy_d;
      bus_err_q   <= bus_err_d;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign cpu_din       = cpu_din_q;
  assign cpu_rdy       = cpu_rdy_q;
  assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb_bus_cycle_ctrl: directed transactions against bus_cycle_ctrl with a
// scoreboard; a monitor checks every request and completion it observes.
`timescale 1ns/1ps

module tb_bus_cycle_ctrl;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } req_exp_t;

  typedef struct {
    logic [7:0] din;
    logic       stall;
    int         len;
    logic       err;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        phi_2 = 1'b0;
  logic [15:0] cpu_addr = 16'h0;
  logic        cpu_rw = 1'b1;
  logic [7:0]  cpu_dout = 8'h0;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic        bus_err;

  req_exp_t    req_q[$];
  done_exp_t   done_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  int          resp_delay = 0;
  logic [7:0]  resp_rdata = 8'h00;
  int          req_cycles = 0;

  bus_cycle_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  bus_cycle_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .phi_2   (phi_2),
    .cpu_addr(cpu_addr),
    .cpu_rw  (cpu_rw),
    .cpu_dout(cpu_dout),
    .cpu_din (cpu_din),
    .cpu_rdy (cpu_rdy),
    .bus_err (bus_err),
    .mem     (mem_bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mem_req"},   32'(mem_bus.mem_req),   32'h0);
    checkOutput({tag, "_mem_we"},    32'(mem_bus.mem_we),    32'h0);
    checkOutput({tag, "_mem_addr"},  32'(mem_bus.mem_addr),  32'h0);
    checkOutput({tag, "_mem_wdata"}, 32'(mem_bus.mem_wdata), 32'h0);
    checkOutput({tag, "_cpu_din"},   32'(cpu_din),           32'h0);
    checkOutput({tag, "_cpu_rdy"},   32'(cpu_rdy),           32'h1);
    checkOutput({tag, "_bus_err"},   32'(bus_err),           32'h0);
  endtask

  // One CPU cycle: phi_2 high for 4 clks, low for 4; entered at a negedge.
  task automatic phiCycle();
    phi_2 = 1'b1;
    repeat (4) @(negedge clk);
    phi_2 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic expectTxn(input logic [15:0] addr, input logic we, input logic [7:0] wdata,
                           input logic [7:0] din, input logic stall, input int len, input logic err);
    req_exp_t  r;
    done_exp_t d;
    r.addr  = addr;
    r.we    = we;
    r.wdata = wdata;
    d.din   = din;
    d.stall = stall;
    d.len   = len;
    d.err   = err;
    req_q.push_back(r);
    done_q.push_back(d);
  endtask

  // Present a CPU cycle; delay is the req cycle in which the responder acks (0 = never).
  task automatic applyStimulus(input logic [15:0] addr, input logic rw, input logic [7:0] dout,
                               input int delay, input logic [7:0] rdata);
    cpu_addr   = addr;
    cpu_rw     = rw;
    cpu_dout   = dout;
    resp_delay = delay;
    resp_rdata = rdata;
    phiCycle();
  endtask

  // Memory responder: acks in the resp_delay-th cycle that mem_req is seen high.
  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 8'hEE;
    forever begin
      @(negedge clk);
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 8'hEE;
      if (mem_bus.mem_req) begin
        req_cycles++;
        if (resp_delay != 0 && req_cycles == resp_delay) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = resp_rdata;
        end
      end else begin
        req_cycles = 0;
      end
    end
  end

  // Monitor: compares each observed request and completion with the scoreboard.
  initial begin
    logic      req_prev;
    int        req_len;
    logic      saw_stall;
    req_exp_t  r;
    done_exp_t d;
    req_prev  = 1'b0;
    req_len   = 0;
    saw_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_prev = 1'b0;
        done_q.delete();
      end else begin
        if (mem_bus.mem_req && !req_prev) begin
          req_len   = 0;
          saw_stall = 1'b0;
          if (req_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_req: got request to 0x%0h, expected none", mem_bus.mem_addr);
          end else begin
            r = req_q.pop_front();
            checkOutput("req_addr",  32'(mem_bus.mem_addr),  32'(r.addr));
            checkOutput("req_we",    32'(mem_bus.mem_we),    32'(r.we));
            checkOutput("req_wdata", 32'(mem_bus.mem_wdata), 32'(r.wdata));
          end
        end
        if (mem_bus.mem_req) begin
          req_len++;
          if (!cpu_rdy) begin
            saw_stall = 1'b1;
          end
        end
        if (!mem_bus.mem_req && req_prev) begin
          if (done_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_done: got completion, expected none");
          end else begin
            d = done_q.pop_front();
            checkOutput("done_din",   32'(cpu_din),   32'(d.din));
            checkOutput("done_stall", 32'(saw_stall), 32'(d.stall));
            checkOutput("done_len",   32'(req_len),   32'(d.len));
            checkOutput("done_err",   32'(bus_err),   32'(d.err));
            checkOutput("done_rdy",   32'(cpu_rdy),   32'h1);
          end
        end
        req_prev = mem_bus.mem_req;
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkResetValues("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] zero-wait read 0x1234");
    expectTxn(16'h1234, 1'b0, 8'h11, 8'h5A, 1'b0, 1, 1'b0);
    applyStimulus(16'h1234, 1'b1, 8'h11, 1, 8'h5A);

    $display("[TB] write 0xC3 to 0x0200, ack in third req cycle");
    expectTxn(16'h0200, 1'b1, 8'hC3, 8'h5A, 1'b0, 3, 1'b0);
    applyStimulus(16'h0200, 1'b0, 8'hC3, 3, 8'hE1);

    $display("[TB] read 0x0340, ack coincident with phi_2 fall");
    expectTxn(16'h0340, 1'b0, 8'h00, 8'h7E, 1'b0, 4, 1'b0);
    applyStimulus(16'h0340, 1'b1, 8'h00, 4, 8'h7E);

    $display("[TB] read 0xBEEF, ack 6 clks after phi_2 fall");
    expectTxn(16'hBEEF, 1'b0, 8'h00, 8'h3C, 1'b1, 10, 1'b0);
    applyStimulus(16'hBEEF, 1'b1, 8'h00, 10, 8'h3C);
    phiCycle();
    phiCycle();
    checkOutput("replay_din", 32'(cpu_din), 32'h3C);
    checkOutput("replay_rdy", 32'(cpu_rdy), 32'h1);

    $display("[TB] write 0xA5 to 0x0001 after replay");
    expectTxn(16'h0001, 1'b1, 8'hA5, 8'h3C, 1'b0, 1, 1'b0);
    applyStimulus(16'h0001, 1'b0, 8'hA5, 1, 8'hE2);

    $display("[TB] stray ack while idle");
    #1;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 8'h66;
    @(negedge clk);
    #1;
    checkOutput("stray_din", 32'(cpu_din),         32'h3C);
    checkOutput("stray_req", 32'(mem_bus.mem_req), 32'h0);
    @(negedge clk);

    $display("[TB] reset while stalled");
    expectTxn(16'h4000, 1'b0, 8'h00, 8'h00, 1'b1, 0, 1'b0);
    applyStimulus(16'h4000, 1'b1, 8'h00, 0, 8'h00);
    checkOutput("stall_rdy", 32'(cpu_rdy), 32'h0);
    checkOutput("stall_err", 32'(bus_err), 32'h0);
    rst_n = 1'b0;
    #1;
    checkResetValues("mid_stall");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expectTxn(16'h4000, 1'b0, 8'h00, 8'h99, 1'b0, 2, 1'b0);
    applyStimulus(16'h4000, 1'b1, 8'h00, 2, 8'h99);

`ifdef BUS_TIMEOUT_EN
    $display("[TB] read 0x5555 with no ack, timeout");
    expectTxn(16'h5555, 1'b0, 8'h00, 8'hFF, 1'b1, TIMEOUT, 1'b1);
    applyStimulus(16'h5555, 1'b1, 8'h00, 0, 8'h00);
    phiCycle();
    phiCycle();
    checkOutput("tmo_din", 32'(cpu_din), 32'hFF);
    checkOutput("tmo_rdy", 32'(cpu_rdy), 32'h1);
    checkOutput("tmo_err", 32'(bus_err), 32'h0);
`endif

    repeat (4) @(negedge clk);
    checkOutput("req_q_empty",  32'(req_q.size()),  32'h0);
    checkOutput("done_q_empty", 32'(done_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_cycle_ctrl.md
# bus_cycle_ctrl

Converts the 2 MHz `phi_2` system clock into single-cycle bus events in the 16 MHz domain and runs one memory transaction per CPU cycle. It sits directly downstream of the clock generator, between the CPU core and the memory/peripheral fabric. Responders are served over a req/ack handshake. A late acknowledge stretches the CPU through `cpu_rdy`.

## Interface
- `ADDR_W`, 16: CPU/memory address width.
- `DATA_W`, 8: data width.
- `TIMEOUT`, 15: maximum number of `clk` cycles that `mem_req` may stay high. Used only with `BUS_TIMEOUT_EN`. Legal range is 1..255.

Ports:
- `clk` in 1: 16 MHz system clock, the same clock that drives the clock generator.
- `rst_n` in 1: asynchronous, active-low reset.
- `phi_2` in 1: 2 MHz system clock, registered in the `clk` domain (4 high / 4 low).
- `cpu_addr` in ADDR_W: CPU address, valid at the `phi_2` rise.
- `cpu_rw` in 1: 1 = read, 0 = write.
- `cpu_dout` in DATA_W: CPU write data.
- `cpu_din` out DATA_W: read data returned to the CPU.
- `cpu_rdy` out 1: 0 stalls the CPU, which then repeats the current cycle.
- `mem_req` out 1: transaction request. Held high until acknowledged.
- `mem_we` out 1: 1 = write.
- `mem_addr` out ADDR_W: latched address.
- `mem_wdata` out DATA_W: latched write data.
- `mem_ack` in 1: one-cycle acknowledge. Honoured only while `mem_req` = 1.
- `mem_rdata` in DATA_W: read data, valid in the `mem_ack` cycle.
- `bus_err` out 1: one-cycle pulse on timeout. Tied to 0 when `BUS_TIMEOUT_EN` is not defined.

## Operation
- Edge detect:
  - `phi_d` holds the registered copy of `phi_2`.
  - `rise = phi_2 & ~phi_d`; `fall = ~phi_2 & phi_d`.
  - No synchronizer is used; `phi_2` is already in the `clk` domain.
- State machine states: IDLE, REQ, DONE, STALL.
- IDLE:
  - On `rise` with `replay` = 0: latch `cpu_addr`, `~cpu_rw` and `cpu_dout` into `mem_addr`, `mem_we` and `mem_wdata`; set `mem_req` = 1; go to REQ.
  - On `rise` with `replay` = 1: clear `replay`, issue no request, go to DONE.
- REQ:
  - On `mem_ack`: clear `mem_req`. If it was a read, load `mem_rdata` into `cpu_din`. Go to DONE.
  - Else on `fall`: set `cpu_rdy` = 0 and go to STALL.
- DONE: on `fall`, go to IDLE.
- STALL:
  - `mem_req` stays high.
  - On `mem_ack`: capture read data, clear `mem_req`, set `cpu_rdy` = 1, set `replay` = 1, go to IDLE.
  - The CPU's repeated cycle is then served from the held `cpu_din`, or the write is treated as already done, without a second request.
- Reads and writes follow the same state machine.
- `cpu_din` holds its value until the next captured read.

## Timing
- Reset values: `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_din` = 0, `cpu_rdy` = 1, `bus_err` = 0, `replay` = 0, `phi_d` = 0, state IDLE.
- `mem_req` rises on the first `clk` edge where `phi_2` = 1 and `phi_d` = 0, i.e. 1 `clk` after `phi_2` goes high.
- Zero-wait ack: `mem_ack` may arrive in the first `mem_req` cycle. `cpu_din` updates on that edge; minimum latency is 2 clks from the `phi_2` rise.
- Non-stall window: an ack is accepted without a stall if it arrives within 4 clks of `mem_req` rising.
- Ack in the same cycle as `fall`: the ack wins; no stall; next state is IDLE.
- `mem_ack` while `mem_req` = 0 is ignored.
- Reset asserted mid-transaction aborts it immediately. No replay follows, and `cpu_rdy` returns to 1.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - An 8-bit counter runs while `mem_req` = 1 and clears when the request ends.
  - When the count reaches `TIMEOUT` without an ack, the transaction is forced complete: `cpu_din` = all ones for reads, `bus_err` pulses for 1 clk, `mem_req` = 0.
  - The state machine then continues as if `mem_ack` had arrived (DONE, or IDLE with `replay` from STALL).
- `BUS_TIMEOUT_EN` not defined: no counter is built; a missing ack stalls the CPU indefinitely; `bus_err` = 0.

## Test plan
- Read, ack in the first req cycle, addr 0x1234, `mem_rdata` 0x5A -> `mem_req` high for exactly 1 clk, `cpu_din` = 0x5A, `cpu_rdy` stays 1.
- Write 0xC3 to 0x0200, ack after 2 clks -> `mem_we` = 1, `mem_addr` = 0x0200, `mem_wdata` = 0xC3, no stall.
- Read with ack 6 clks after the `phi_2` fall -> `cpu_rdy` = 0 from the fall until the ack; next cycle has the same address, no second `mem_req`, `cpu_din` holds the data.
- Ack coincident with the `fall` edge -> no stall, `cpu_rdy` = 1 throughout.
- Reset pulsed while in STALL -> all outputs at reset values; the next `phi_2` rise issues a fresh request.
- With `BUS_TIMEOUT_EN`, `TIMEOUT` = 15, no ack -> `bus_err` pulses 15 clks after `mem_req` rises; `cpu_din` = 0xFF; `cpu_rdy` returns to 1.
